// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and one-entry fetch register between the
// instruction ROM (combinational read) and the decode stage. Handles start/halt,
// decode stall, taken-branch redirect with wrong-path drop, and sticky PC-wrap flag.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    INSTR_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt_req,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic                   running,
    output logic                   done,
    output logic                   pc_wrap
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [ADDR_WIDTH-1:0]  pc_q,        pc_d;
    logic [INSTR_WIDTH-1:0] instr_q,     instr_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q,  instr_pc_d;
    logic                   valid_q,     valid_d;
    logic                   wrap_q,      wrap_d;
    logic                   running_q,   running_d;
    logic                   done_q,      done_d;

    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic                   pc_at_max;

    // Increment is naturally modulo 2^ADDR_WIDTH; all-ones is the wrap point.
    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign pc_at_max = &pc_q;

    // The ROM has no enable, so its address is the PC in every state.
    assign rom_addr    = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pc_wrap     = wrap_q;

    // Next-state logic: FETCH priority is halt > stall > branch > sequential fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        wrap_d     = wrap_q;

        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_ADDR;
                end
            end

            S_FETCH: begin
                if (halt_req) begin
                    // Stall is irrelevant once decode has seen the halt.
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Everything holds; a pending branch waits for stall to drop.
                end else if (branch_taken) begin
                    // The word on rom_data this cycle is wrong-path: drop it.
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else begin
                    instr_d    = rom_data;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_inc;
                    // Only a sequential step can wrap; a redirect never sets the flag.
                    if (pc_at_max) begin
                        wrap_d = 1'b1;
                    end
                end
            end

            S_HALTED: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_ADDR;
                    wrap_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                pc_d    = START_ADDR;
                valid_d = 1'b0;
            end
        endcase

        running_d = (state_d == S_FETCH);
        done_d    = (state_d == S_HALTED);
    end

    // State and registered outputs; reset discards the fetch register and the wrap flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= START_ADDR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

endmodule
